// File: rtl/jt900h_irqgen_pkg.sv
// Shared definitions for the jt900h programmable interrupt generator.
// Register offsets, CTRL bit positions and the per-channel status bundle.
package jt900h_irqgen_pkg;

  localparam int LW = 3;

  localparam logic       OFS_CTRL  = 1'b0;
  localparam logic       OFS_COUNT = 1'b1;
  localparam logic [3:0] ADDR_MASK = 4'd15;

  localparam int CTRL_EN     = 3;
  localparam int CTRL_RELOAD = 4;
  localparam int CTRL_PEND   = 7;

  typedef struct packed {
    logic [LW-1:0] lvl;
    logic          en;
    logic          reload;
    logic          pend;
  } ch_stat_t;

  function automatic logic [15:0] ctrl_word(ch_stat_t s);
    logic [15:0] w;
    w                = '0;
    w[LW-1:0]        = s.lvl;
    w[CTRL_EN]       = s.en;
    w[CTRL_RELOAD]   = s.reload;
    w[CTRL_PEND]     = s.pend;
    return w;
  endfunction

endpackage

// File: rtl/jt900h_irqgen_ch.sv
// One interrupt channel: countdown, reload/one-shot and pending flag.
// Expiry sees the pre-write CTRL values; an expiry beats any clear.
module jt900h_irqgen_ch
  import jt900h_irqgen_pkg::*;
#(
  parameter int CW = 12
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cen,
  input  logic          ctrl_we,
  input  logic          count_we,
  input  logic [1:0]    we,
  input  logic [15:0]   din,
  input  logic          ack_clr,
  output ch_stat_t      stat,
  output logic [CW-1:0] cnt
);

  logic [CW-1:0] rld;
  logic [CW-1:0] rld_nx;
  logic [15:0]   rld16;
  logic [15:0]   wr16;
  logic          run;
  logic          expire;
  logic          w1c;

  assign run    = stat.en & cen;
  assign expire = run & (cnt == '0);
  assign w1c    = ctrl_we & we[0] & din[CTRL_PEND];

  // Byte merge against the stored reload value, masked to CW bits
  always_comb begin
    rld16 = 16'(rld);
    wr16  = rld16;
    if (we[0]) wr16[7:0]  = din[7:0];
    if (we[1]) wr16[15:8] = din[15:8];
    rld_nx = wr16[CW-1:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat <= '0;
      cnt  <= '0;
      rld  <= '0;
    end else begin
      if (run) begin
        if (cnt == '0) begin
          if (stat.reload) cnt <= rld;
          else stat.en <= 1'b0;
        end else begin
          cnt <= cnt - CW'(1);
        end
      end
      if (count_we) begin
        rld <= rld_nx;
        cnt <= rld_nx;
      end
      if (ctrl_we && we[0]) begin
        stat.lvl    <= din[LW-1:0];
        stat.en     <= din[CTRL_EN];
        stat.reload <= din[CTRL_RELOAD];
      end
      if (ack_clr || w1c) stat.pend <= 1'b0;
      if (expire && stat.lvl != '0) stat.pend <= 1'b1;
    end
  end

endmodule

// File: rtl/jt900h_irqgen.sv
// Multi-channel memory-mapped interrupt generator for the jt900h CPU.
// Optional MASK register at addr 15 enabled by JT900H_IRQ_MASK_EN.
module jt900h_irqgen
  import jt900h_irqgen_pkg::*;
#(
  parameter int          CH    = 4,
  parameter int          CW    = 12,
  parameter logic [23:0] VBASE = 24'hFFFF20
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cen,
  input  logic          cs,
  input  logic [3:0]    addr,
  input  logic [15:0]   din,
  input  logic [1:0]    we,
  output logic [15:0]   dout,
  output logic          irq,
  output logic [LW-1:0] int_lvl,
  output logic [23:0]   int_addr,
  input  logic          irq_ack
);

  ch_stat_t      stat [CH];
  logic [CW-1:0] cnt  [CH];

  logic [CH-1:0] ctrl_wr;
  logic [CH-1:0] cnt_wr;
  logic [CH-1:0] ack_clr;

  logic [2:0]    ach;
  logic          bus_wr;
  logic          mask_hit;
  logic          ch_ok;

  logic [2:0]    sel;
  logic [2:0]    best;
  logic [LW-1:0] best_lvl;
  logic          found;
  logic          irq_nx;

  assign ach    = addr[3:1];
  assign bus_wr = cs & (|we);

`ifdef JT900H_IRQ_MASK_EN
  logic [LW-1:0] mask;

  assign mask_hit = (addr == ADDR_MASK);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) mask <= '0;
    else if (bus_wr && mask_hit && we[0]) mask <= din[LW-1:0];
  end
`else
  assign mask_hit = 1'b0;
`endif

  assign ch_ok = (int'(ach) < CH) && !mask_hit;

  always_comb begin
    for (int i = 0; i < CH; i++) begin
      ctrl_wr[i] = bus_wr && ch_ok && int'(ach) == i
                   && addr[0] == OFS_CTRL;
      cnt_wr[i]  = bus_wr && ch_ok && int'(ach) == i
                   && addr[0] == OFS_COUNT;
      ack_clr[i] = irq_ack && irq && int'(sel) == i;
    end
  end

  for (genvar g = 0; g < CH; g++) begin : g_ch
    jt900h_irqgen_ch #(
      .CW(CW)
    ) u_ch (
      .clk      (clk),
      .rst      (rst),
      .cen      (cen),
      .ctrl_we  (ctrl_wr[g]),
      .count_we (cnt_wr[g]),
      .we       (we),
      .din      (din),
      .ack_clr  (ack_clr[g]),
      .stat     (stat[g]),
      .cnt      (cnt[g])
    );
  end

  // Strict compare keeps the lowest index on equal levels
  always_comb begin
    found    = 1'b0;
    best     = '0;
    best_lvl = '0;
    for (int i = 0; i < CH; i++) begin
      if (stat[i].pend && (!found || stat[i].lvl > best_lvl)) begin
        found    = 1'b1;
        best     = 3'(i);
        best_lvl = stat[i].lvl;
      end
    end
  end

`ifdef JT900H_IRQ_MASK_EN
  assign irq_nx = found && (best_lvl > mask || best_lvl == 3'd7);
`else
  assign irq_nx = found;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      irq      <= 1'b0;
      sel      <= '0;
      int_lvl  <= '0;
      int_addr <= VBASE;
    end else begin
      irq <= irq_nx;
      if (found) begin
        sel      <= best;
        int_lvl  <= best_lvl;
        int_addr <= VBASE + {19'd0, best, 2'b00};
      end else begin
        sel      <= '0;
        int_lvl  <= '0;
        int_addr <= VBASE;
      end
    end
  end

  always_comb begin
    dout = '0;
    if (cs) begin
`ifdef JT900H_IRQ_MASK_EN
      if (mask_hit) dout = 16'(mask);
`endif
      if (ch_ok) begin
        for (int i = 0; i < CH; i++) begin
          if (int'(ach) == i) begin
            if (addr[0] == OFS_COUNT) dout = 16'(cnt[i]);
            else dout = ctrl_word(stat[i]);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_jt900h_irqgen.sv
// Randomized bench for jt900h_irqgen against a level-first reference model.
// Directed scenarios pin the model with literal expectations.
module tb_jt900h_irqgen;

  localparam int CH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cen = 1'b1;
  logic        cs = 1'b0;
  logic        irq_ack = 1'b0;
  logic [3:0]  addr = '0;
  logic [15:0] din = '0;
  logic [1:0]  we = '0;
  logic [15:0] dout;
  logic        irq;
  logic [2:0]  int_lvl;
  logic [23:0] int_addr;

  always #5 clk = ~clk;

  jt900h_irqgen #(
    .CH(CH), .CW(12), .VBASE(24'hFFFF20)
  ) dut (
    .clk(clk), .rst(rst), .cen(cen), .cs(cs), .addr(addr),
    .din(din), .we(we), .dout(dout), .irq(irq),
    .int_lvl(int_lvl), .int_addr(int_addr), .irq_ack(irq_ack)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit tog = 0;

  int m_lvl[CH], m_en[CH], m_rl[CH], m_pend[CH], m_cnt[CH], m_rld[CH];
  int n_lvl[CH], n_en[CH], n_rl[CH], n_pend[CH], n_cnt[CH], n_rld[CH];
  int m_irq = 0, m_ilvl = 0, m_sel = 0, m_mask = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors < 30)
        $display("FAIL %s t=%0t actual=%h required=%h", nm, $time, act, exp);
    end
  endtask

  function automatic logic [15:0] m_dout();
    int c;
    if (!cs) return 16'h0;
`ifdef JT900H_IRQ_MASK_EN
    if (addr == 4'd15) return 16'(m_mask);
`endif
    c = int'(addr) / 2;
    if (c >= CH) return 16'h0;
    if (addr[0]) return 16'(m_cnt[c]);
    return 16'(m_pend[c] * 128 + m_rl[c] * 16 + m_en[c] * 8 + m_lvl[c]);
  endfunction

  // Reference model: evaluated from the pre-edge state at every rising edge
  always @(posedge clk) begin
    int best, blvl, c, bm, a, merged, nirq;
    bit wr, valid, ack, fire;
    cyc++;
    if (!rst) begin
      for (int k = 0; k < CH; k++) begin
        m_lvl[k] = 0; m_en[k] = 0; m_rl[k] = 0;
        m_pend[k] = 0; m_cnt[k] = 0; m_rld[k] = 0;
      end
      m_irq = 0; m_ilvl = 0; m_sel = 0; m_mask = 0;
    end else begin
      best = -1; blvl = 0;
      for (int lv = 7; lv >= 0; lv--)
        for (int k = 0; k < CH; k++)
          if (best < 0 && m_pend[k] != 0 && m_lvl[k] == lv) begin
            best = k; blvl = lv;
          end
      nirq = (best >= 0) ? 1 : 0;
`ifdef JT900H_IRQ_MASK_EN
      if (best >= 0 && !(blvl > m_mask || blvl == 7)) nirq = 0;
`endif
      ack = irq_ack && m_irq != 0;
      wr = cs && we != 2'b00;
      a = int'(addr);
      c = a / 2;
      valid = c < CH;
`ifdef JT900H_IRQ_MASK_EN
      if (a == 15) valid = 0;
`endif
      bm = (we[0] ? 'h00FF : 0) | (we[1] ? 'hFF00 : 0);
      for (int k = 0; k < CH; k++) begin
        n_lvl[k] = m_lvl[k]; n_en[k] = m_en[k]; n_rl[k] = m_rl[k];
        n_pend[k] = m_pend[k]; n_cnt[k] = m_cnt[k]; n_rld[k] = m_rld[k];
        fire = m_en[k] != 0 && cen && m_cnt[k] == 0;
        if (m_en[k] != 0 && cen) begin
          if (m_cnt[k] > 0) n_cnt[k] = m_cnt[k] - 1;
          else if (m_rl[k] != 0) n_cnt[k] = m_rld[k];
          else n_en[k] = 0;
        end
        if (wr && valid && c == k) begin
          if (a % 2 == 0) begin
            if (we[0]) begin
              n_lvl[k] = int'(din[2:0]);
              n_en[k] = int'(din[3]);
              n_rl[k] = int'(din[4]);
              if (din[7]) n_pend[k] = 0;
            end
          end else begin
            merged = ((m_rld[k] & ~bm) | (int'(din) & bm)) & 'hFFF;
            n_rld[k] = merged;
            n_cnt[k] = merged;
          end
        end
        if (ack && m_sel == k) n_pend[k] = 0;
        if (fire && m_lvl[k] != 0) n_pend[k] = 1;
      end
      for (int k = 0; k < CH; k++) begin
        m_lvl[k] = n_lvl[k]; m_en[k] = n_en[k]; m_rl[k] = n_rl[k];
        m_pend[k] = n_pend[k]; m_cnt[k] = n_cnt[k]; m_rld[k] = n_rld[k];
      end
`ifdef JT900H_IRQ_MASK_EN
      if (wr && a == 15 && we[0]) m_mask = int'(din[2:0]);
`endif
      m_irq = nirq;
      m_ilvl = (best >= 0) ? blvl : 0;
      m_sel = (best >= 0) ? best : 0;
    end
  end

  always @(posedge clk) begin
    #1;
    chk("irq", 32'(irq), 32'(m_irq));
    chk("int_lvl", 32'(int_lvl), 32'(m_ilvl));
    chk("int_addr", 32'(int_addr), 32'h00FFFF20 + 32'(4 * m_sel));
    chk("dout", 32'(dout), 32'(m_dout()));
  end

  always @(negedge clk) if (tog) cen = ~cen;

  task automatic wr(input logic [3:0] a, input logic [15:0] d);
    @(negedge clk); cs = 1'b1; addr = a; din = d; we = 2'b11;
    @(negedge clk); cs = 1'b0; we = 2'b00;
  endtask

  task automatic ack_pulse();
    @(negedge clk); irq_ack = 1'b1;
    @(negedge clk); irq_ack = 1'b0;
  endtask

  task automatic rd(input logic [3:0] a, input string nm,
                    input logic [15:0] exp);
    @(negedge clk); cs = 1'b1; addr = a; we = 2'b00;
    #1 chk(nm, 32'(dout), 32'(exp));
    cs = 1'b0;
  endtask

  task automatic wait_irq(input int lim, output int at);
    at = -1;
    for (int k = 0; k < lim; k++) begin
      @(posedge clk); #1;
      if (irq) begin at = cyc; break; end
    end
    chk("irq_wait", 32'(at >= 0), 32'd1);
  endtask

  initial begin
    int t1, t2;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_irq", 32'(irq), 32'd0);
    chk("rst_lvl", 32'(int_lvl), 32'd0);
    chk("rst_addr", 32'(int_addr), 32'h00FFFF20);
    @(negedge clk); rst = 1'b1;

    // Reset in the middle of a countdown
    wr(4'd1, 16'd5);
    wr(4'd0, 16'h000B);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1 cs = 1'b1; addr = 4'd1;
    #1 chk("midrst_count", 32'(dout), 32'd0);
    chk("midrst_irq", 32'(irq), 32'd0);
    @(negedge clk); rst = 1'b1; cs = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      chk("postrst_irq", 32'(irq), 32'd0);
    end

    // One-shot on channel 1
    wr(4'd3, 16'd10);
    wr(4'd2, 16'h000C);
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk); #1;
      chk("oneshot_irq", 32'(irq), 32'(k == 12));
    end
    chk("oneshot_lvl", 32'(int_lvl), 32'd4);
    chk("oneshot_addr", 32'(int_addr), 32'h00FFFF24);
    ack_pulse();
    @(posedge clk); #1;
    chk("oneshot_ackdrop", 32'(irq), 32'd0);
    rd(4'd2, "oneshot_ctrl", 16'h0004);

    // Priority and tie-break
    @(negedge clk); cen = 1'b0;
    wr(4'd1, 16'd3); wr(4'd5, 16'd3); wr(4'd7, 16'd3);
    wr(4'd0, 16'h000A); wr(4'd4, 16'h000D); wr(4'd6, 16'h000D);
    cen = 1'b1;
    wait_irq(20, t1);
    chk("prio_first", 32'(int_addr), 32'h00FFFF28);
    chk("prio_lvl", 32'(int_lvl), 32'd5);
    ack_pulse();
    @(posedge clk); #1;
    chk("prio_second", 32'(int_addr), 32'h00FFFF2C);
    ack_pulse();
    @(posedge clk); #1;
    chk("prio_third", 32'(int_addr), 32'h00FFFF20);
    chk("prio_third_lvl", 32'(int_lvl), 32'd2);
    ack_pulse();
    @(posedge clk); #1;
    chk("prio_done", 32'(irq), 32'd0);

    // Auto-reload with cen toggling each clock
    wr(4'd1, 16'd3);
    wr(4'd0, 16'h0019);
    tog = 1'b1;
    wait_irq(40, t1);
    ack_pulse();
    wait_irq(40, t2);
    chk("reload_period", 32'(t2 - t1), 32'd8);
    ack_pulse();
    repeat (5) @(negedge clk);
    cs = 1'b1; addr = 4'd0; din = 16'h0099; we = 2'b01;
    @(negedge clk); we = 2'b00;
    #1 chk("w1c_vs_expiry", 32'(dout[7]), 32'd1);
    cs = 1'b0;
    tog = 1'b0;
    @(negedge clk); cen = 1'b1;
    wr(4'd0, 16'h0080);

    // Ack colliding with expiry every cycle
    wr(4'd1, 16'd0);
    wr(4'd0, 16'h0019);
    wait_irq(10, t1);
    @(negedge clk); irq_ack = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      chk("collide_irq", 32'(irq), 32'd1);
      chk("collide_addr", 32'(int_addr), 32'h00FFFF20);
    end
    @(negedge clk); irq_ack = 1'b0;
    wr(4'd0, 16'h0080);

`ifdef JT900H_IRQ_MASK_EN
    wr(4'd15, 16'd4);
    wr(4'd1, 16'd0);
    wr(4'd0, 16'h000B);
    repeat (5) @(posedge clk);
    #1 chk("mask_noirq", 32'(irq), 32'd0);
    rd(4'd0, "mask_pend", 16'h0083);
    wr(4'd15, 16'd2);
    @(posedge clk); #1;
    chk("mask_lowered", 32'(irq), 32'd1);
    wr(4'd0, 16'h0080);
    wr(4'd15, 16'd7);
    wr(4'd3, 16'd0);
    wr(4'd2, 16'h000F);
    wait_irq(6, t1);
    chk("mask_nmi_lvl", 32'(int_lvl), 32'd7);
    wr(4'd2, 16'h0080);
`endif

    // Randomized traffic, checked cycle by cycle against the model
    for (int n = 0; n < 1500; n++) begin
      @(negedge clk);
      cen = ($urandom_range(0, 3) != 0);
      irq_ack = ($urandom_range(0, 4) == 0);
      if ($urandom_range(0, 3) == 0) begin
        cs = 1'b1;
        addr = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(8, 15))
                                           : 4'($urandom_range(0, 7));
        we = 2'($urandom_range(1, 3));
        if (addr[0] && $urandom_range(0, 3) != 0)
          din = 16'($urandom_range(0, 12));
        else
          din = 16'($urandom);
      end else begin
        cs = 1'($urandom_range(0, 1));
        addr = 4'($urandom_range(0, 15));
        we = 2'b00;
      end
    end
    @(negedge clk);
    cs = 1'b0; we = 2'b00; irq_ack = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
